mul_share_arbiter: RTL

- Shares one fixed-latency 8x8->16 arithmetic datapath (operands data_a/data_b, 16-bit result) between NUM_REQ requesters.
- Each requester uses a valid/ready handshake; the block grants one requester per cycle round-robin and drives the datapath operands.
- It tracks each in-flight operation's owner through a tag pipeline and returns the result to that owner.
- Sits between requester clients and the shared datapath instance; the datapath itself is outside this block.

---
 rtl/mul_share_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one fixed-latency 8x8->16 datapath between NUM_REQ requesters.
// A tag pipeline tracks each operation's owner so the result goes back to the requester that issued it.
module mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 2,
  parameter int IDX_W      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_a_i,
  input  logic [8*NUM_REQ-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   dp_issue_o,
  output logic [7:0]             dp_a_o,
  output logic [7:0]             dp_b_o,
  input  logic [15:0]            dp_result_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [15:0]            rsp_result_o,
  output logic                   busy_o,
  output logic [15:0]            issue_cnt_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Handshake: an operation transfers from requester k when req_valid_i[k] and
  // req_ready_o[k] are both high at a rising clk_i edge. Grants are one-hot and
  // may depend combinationally on req_valid_i; responses have no backpressure.

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         dp_a_q, dp_b_q;
  logic               dp_issue_q;
  logic [15:0]        issue_cnt_q;
  logic [DP_LATENCY:0] tag_v_q;
  logic [IDX_W-1:0]   tag_idx_q [0:DP_LATENCY];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_result_q;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  int                 cand;

  assign busy = (|tag_v_q) | (|rsp_valid_q);

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = 0;
    if (state_q == ST_RUN && en_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!grant_found && req_valid_i[cand]) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                  ptr_d = grant_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_i) state_d = ST_RUN;
      ST_RUN:   if (!en_i) state_d = busy ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (en_i)       state_d = ST_RUN;
        else if (!busy) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = '0;
    if (tag_v_q[DP_LATENCY]) rsp_valid_d[tag_idx_q[DP_LATENCY]] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_issue_q   <= 1'b0;
      issue_cnt_q  <= '0;
      tag_v_q      <= '0;
      for (int s = 0; s <= DP_LATENCY; s++) tag_idx_q[s] <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dp_issue_q <= grant_found;
      if (grant_found) begin
        dp_a_q      <= req_a_i[8*int'(grant_idx) +: 8];
        dp_b_q      <= req_b_i[8*int'(grant_idx) +: 8];
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
      tag_v_q[0]   <= grant_found;
      tag_idx_q[0] <= grant_idx;
      for (int s = 1; s <= DP_LATENCY; s++) begin
        tag_v_q[s]   <= tag_v_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      rsp_valid_q <= rsp_valid_d;
      if (tag_v_q[DP_LATENCY]) rsp_result_q <= dp_result_i;
    end
  end

  assign req_ready_o  = grant;
  assign dp_issue_o   = dp_issue_q;
  assign dp_a_o       = dp_a_q;
  assign dp_b_o       = dp_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o       = busy;
  assign issue_cnt_o  = issue_cnt_q;
  assign state_o      = state_q;

endmodule
